// File: rtl/button_pkg.sv
// Shared types and default timing constants for the button gesture logic.
//   click_st_t          : gesture decoder state encoding
//   TICK_DIV_100MHZ_1MS : clk cycles per 1 ms timebase tick at 100 MHz
//   LONG_TICKS_DEF      : default long-press threshold in ticks
//   GAP_TICKS_DEF       : default double-click gap window in ticks
package button_pkg;

  typedef enum logic [2:0] {
    C_IDLE   = 3'd0,
    C_PRESS1 = 3'd1,
    C_HELD   = 3'd2,
    C_GAP    = 3'd3,
    C_PRESS2 = 3'd4
  } click_st_t;

  localparam int unsigned TICK_DIV_100MHZ_1MS = 100000;
  localparam int unsigned LONG_TICKS_DEF      = 800;
  localparam int unsigned GAP_TICKS_DEF       = 250;

endpackage

// File: rtl/click_timer.sv
// Prescaled timebase for the click decoder: a prescaler producing one tick
// every TICK_DIV clocks, plus a saturating count of ticks since the last clear.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-high reset
//   clear    : synchronous restart of prescaler and tick counter
//   tick     : high in the last prescaler cycle of each TICK_DIV period
//   tick_cnt : ticks seen since the last clear, saturating at all-ones
module click_timer
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_100MHZ_1MS,
  parameter int unsigned TICK_W   = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              tick,
  output logic [TICK_W-1:0] tick_cnt
);

  localparam int unsigned      PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick     = (pre_q == PRE_MAX);
  assign tick_cnt = cnt_q;

  always_comb begin
    pre_d = pre_q + 1'b1;
    cnt_d = cnt_q;
    if (tick) begin
      pre_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/click_decoder.sv
// Classifies a clean button level into short click, double click and long
// press gestures, timed by a prescaled tick timebase restarted on every state
// change.
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   btn_level    : debounced, clk-synchronous button level (1 = pressed)
//   short_click  : one-cycle pulse, single short press recognised
//   double_click : one-cycle pulse, two presses within the gap window
//   long_press   : one-cycle pulse, first press held for LONG_TICKS
//   held         : high while in the held state
//   event_cnt    : wrapping count of all recognised events
module click_decoder
  import button_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_100MHZ_1MS,
  parameter int unsigned LONG_TICKS = LONG_TICKS_DEF,
  parameter int unsigned GAP_TICKS  = GAP_TICKS_DEF,
  parameter int unsigned TICK_W     = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_level,
  output logic       short_click,
  output logic       double_click,
  output logic       long_press,
  output logic       held,
  output logic [7:0] event_cnt
);

  localparam logic [TICK_W-1:0] LONG_LAST = TICK_W'(LONG_TICKS - 1);
  localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);

  click_st_t         state_q, state_d;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic              long_to, gap_to;

  logic       short_q, short_d;
  logic       double_q, double_d;
  logic       long_q, long_d;
  logic       held_q, held_d;
  logic [7:0] event_cnt_q, event_cnt_d;

  // Restarting the timebase in the decision cycle makes the entry cycle of the
  // new state see prescaler=0, so timeout T lands on its T*TICK_DIV-th cycle.
  click_timer #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .tick     (tick),
    .tick_cnt (tick_cnt)
  );

  assign long_to = tick && (tick_cnt == LONG_LAST);
  assign gap_to  = tick && (tick_cnt == GAP_LAST);

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (btn_level) state_d = C_PRESS1;
      end
      C_PRESS1: begin
        // Release takes priority over a coincident long timeout.
        if (!btn_level) begin
          state_d = C_GAP;
        end else if (long_to) begin
          state_d = C_HELD;
          long_d  = 1'b1;
        end
      end
      C_HELD: begin
        if (!btn_level) state_d = C_IDLE;
      end
      C_GAP: begin
        // A second press takes priority over a coincident gap timeout.
        if (btn_level) begin
          state_d = C_PRESS2;
        end else if (gap_to) begin
          state_d = C_IDLE;
          short_d = 1'b1;
        end
      end
      C_PRESS2: begin
        if (!btn_level) begin
          state_d  = C_IDLE;
          double_d = 1'b1;
        end
      end
      default: state_d = C_IDLE;
    endcase
    held_d      = (state_d == C_HELD);
    event_cnt_d = event_cnt_q + {7'd0, (short_d | double_d | long_d)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= C_IDLE;
      short_q     <= 1'b0;
      double_q    <= 1'b0;
      long_q      <= 1'b0;
      held_q      <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      short_q     <= short_d;
      double_q    <= double_d;
      long_q      <= long_d;
      held_q      <= held_d;
      event_cnt_q <= event_cnt_d;
    end
  end

  assign short_click  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign held         = held_q;
  assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_click_decoder.sv
// Self-checking bench for click_decoder with TICK_DIV=4, LONG_TICKS=5,
// GAP_TICKS=3 (long press = 20 cycles, gap window = 12 cycles).
module tb_click_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_level;
  logic       short_click;
  logic       double_click;
  logic       long_press;
  logic       held;
  logic [7:0] event_cnt;

  click_decoder #(
    .TICK_DIV   (4),
    .LONG_TICKS (5),
    .GAP_TICKS  (3),
    .TICK_W     (12)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_level    (btn_level),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press),
    .held         (held),
    .event_cnt    (event_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_short  = 0;
  int n_double = 0;
  int n_long   = 0;

  typedef struct {
    int p1;   // first press length in cycles
    int g;    // release length before second press
    int p2;   // second press length, 0 = no second press
    int e_s;  // expected short clicks
    int e_d;  // expected double clicks
    int e_l;  // expected long presses
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (short_click === 1'b1) n_short++;
    if (double_click === 1'b1) n_double++;
    if (long_press === 1'b1) n_long++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    btn_level = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string name);
    check({name, " outputs"},
          {28'd0, short_click, double_click, long_press, held}, 32'd0);
    check({name, " event_cnt"}, {24'd0, event_cnt}, 32'd0);
  endtask

  initial begin
    int s0, d0, l0, bad_s, bad_o, bad_h, bad_l;
    logic [7:0] c0;

    vecs[0] = '{6, 0, 0, 1, 0, 0};
    vecs[1] = '{6, 5, 6, 0, 1, 0};
    vecs[2] = '{40, 0, 0, 0, 0, 1};
    vecs[3] = '{20, 0, 0, 1, 0, 0};   // release on 20th PRESS1 cycle wins
    vecs[4] = '{21, 0, 0, 0, 0, 1};
    vecs[5] = '{6, 12, 6, 0, 1, 0};   // press on 12th GAP cycle wins
    vecs[6] = '{6, 13, 6, 2, 0, 0};
    vecs[7] = '{20, 12, 30, 0, 1, 0}; // both races, then long PRESS2
    vecs[8] = '{1, 0, 0, 1, 0, 0};
    vecs[9] = '{6, 1, 1, 0, 1, 0};

    reset = 1'b1;
    btn_level = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    reset = 1'b0;
    step();
    check_all_zero("post_reset");

    // Short click timing: pulse exactly 13 edges after the release is driven.
    btn_level = 1'b1;
    repeat (6) step();
    btn_level = 1'b0;
    bad_s = 0;
    bad_o = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 13) check("short_timing", {31'd0, short_click}, 32'd1);
      else if (short_click !== 1'b0) bad_s++;
      if (double_click !== 1'b0 || long_press !== 1'b0 || held !== 1'b0) bad_o++;
    end
    check("short_extra_pulses", bad_s, 0);
    check("short_other_outputs", bad_o, 0);
    check("short_event_cnt", {24'd0, event_cnt}, 32'd1);

    // Double click: pulse the cycle after the second release is seen.
    do_reset();
    btn_level = 1'b1;
    repeat (6) step();
    btn_level = 1'b0;
    repeat (5) step();
    btn_level = 1'b1;
    repeat (6) step();
    s0 = n_short;
    btn_level = 1'b0;
    check("double_before", {31'd0, double_click}, 32'd0);
    step();
    check("double_timing", {31'd0, double_click}, 32'd1);
    check("double_event_cnt", {24'd0, event_cnt}, 32'd1);
    step();
    check("double_width", {31'd0, double_click}, 32'd0);
    repeat (20) step();
    check("double_no_short", n_short - s0, 0);

    // Long press: pulse and held both rise after the 21st edge of the press.
    do_reset();
    s0 = n_short;
    d0 = n_double;
    bad_l = 0;
    bad_h = 0;
    btn_level = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (long_press !== ((i == 21) ? 1'b1 : 1'b0)) bad_l++;
      if (held !== ((i >= 21) ? 1'b1 : 1'b0)) bad_h++;
    end
    check("long_pulse_profile", bad_l, 0);
    check("held_profile", bad_h, 0);
    btn_level = 1'b0;
    check("held_before_release", {31'd0, held}, 32'd1);
    step();
    check("held_after_release", {31'd0, held}, 32'd0);
    repeat (20) step();
    check("long_no_short_double", (n_short - s0) + (n_double - d0), 0);
    check("long_event_cnt", {24'd0, event_cnt}, 32'd1);

    // Table of gestures.
    for (int v = 0; v < 10; v++) begin
      s0 = n_short;
      d0 = n_double;
      l0 = n_long;
      c0 = event_cnt;
      btn_level = 1'b1;
      repeat (vecs[v].p1) step();
      btn_level = 1'b0;
      if (vecs[v].p2 > 0) begin
        repeat (vecs[v].g) step();
        btn_level = 1'b1;
        repeat (vecs[v].p2) step();
        btn_level = 1'b0;
      end
      repeat (40) step();
      check($sformatf("vec%0d short", v), n_short - s0, vecs[v].e_s);
      check($sformatf("vec%0d double", v), n_double - d0, vecs[v].e_d);
      check($sformatf("vec%0d long", v), n_long - l0, vecs[v].e_l);
      check($sformatf("vec%0d event_cnt", v), {24'd0, 8'(event_cnt - c0)},
            {24'd0, 8'(vecs[v].e_s + vecs[v].e_d + vecs[v].e_l)});
      check($sformatf("vec%0d held", v), {31'd0, held}, 32'd0);
    end

    // Reset during GAP aborts the pending short click.
    do_reset();
    btn_level = 1'b1;
    repeat (6) step();
    btn_level = 1'b0;
    repeat (30) step();
    btn_level = 1'b1;
    repeat (6) step();
    btn_level = 1'b0;
    repeat (5) step();
    s0 = n_short;
    reset = 1'b1;
    step();
    check_all_zero("reset_gap");
    reset = 1'b0;
    repeat (30) step();
    check("reset_gap_no_short", n_short - s0, 0);
    check("reset_gap_cnt_after", {24'd0, event_cnt}, 32'd0);

    // Reset during HELD.
    btn_level = 1'b1;
    repeat (25) step();
    check("reset_held_pre", {31'd0, held}, 32'd1);
    reset = 1'b1;
    btn_level = 1'b0;
    step();
    check_all_zero("reset_held");
    reset = 1'b0;
    s0 = n_short;
    d0 = n_double;
    l0 = n_long;
    repeat (30) step();
    check("reset_held_no_pulse", (n_short - s0) + (n_double - d0) + (n_long - l0), 0);
    check("reset_held_idle", {31'd0, held}, 32'd0);

    // event_cnt wraps after 256 events.
    do_reset();
    s0 = n_short;
    for (int i = 1; i <= 256; i++) begin
      btn_level = 1'b1;
      step();
      btn_level = 1'b0;
      repeat (14) step();
      if (i == 255) check("wrap_255", {24'd0, event_cnt}, 32'd255);
    end
    check("wrap_shorts", n_short - s0, 256);
    check("wrap_0", {24'd0, event_cnt}, 32'd0);
    btn_level = 1'b1;
    step();
    btn_level = 1'b0;
    repeat (14) step();
    check("wrap_1", {24'd0, event_cnt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
